// File: rtl/mdu_ctrl_if.sv
// EX-stage to multiply/divide unit bundle: request, operands and flush in;
// stall, busy and the architectural HI/LO values out.
interface mdu_ctrl_if;
    logic        req;
    logic [2:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output req, mdu_op, src_a, src_b, flush,
        input  stall, busy, hi_o, lo_o
    );

    modport slave (
        input  req, mdu_op, src_a, src_b, flush,
        output stall, busy, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the EX stage: owns HI/LO, runs multi-cycle
// MULT/MULTU/DIV/DIVU and single-cycle MTHI/MTLO, and stalls the pipeline.
module mdu_ctrl #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic      clk,
    input  logic      rst,
    mdu_ctrl_if.slave bus
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
    localparam logic [4:0] DIV_LAST = 5'(DIV_ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [4:0]  cnt_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    // opb_r holds the multiplier or |divisor|; quo_r doubles as multiplicand
    logic [31:0] opb_r;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic        mul_signed_r;
    logic        quo_neg_r;
    logic        rem_neg_r;
    logic        div_zero_r;

    logic        is_mul_s;
    logic        is_div_s;
    logic        div_signed_s;
    logic        stall_s;
    logic        busy_s;
    logic        acc_mul_s;
    logic        acc_div_s;
    logic        mthi_we_s;
    logic        mtlo_we_s;
    logic        mul_done_s;
    logic        div_done_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic [32:0] shl_s;
    logic [32:0] diff_s;
    logic [31:0] rem_step_s;
    logic [31:0] quo_step_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;

    // Two's-complement negate when neg is set; 0x80000000 maps onto itself.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        logic [31:0] r;
        if (neg) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Opcode classification of the instruction sitting in EX
    always_comb begin
        is_mul_s     = 1'b0;
        is_div_s     = 1'b0;
        div_signed_s = 1'b0;
        case (bus.mdu_op)
            OP_MULT, OP_MULTU: is_mul_s = 1'b1;
            OP_DIV: begin
                is_div_s     = 1'b1;
                div_signed_s = 1'b1;
            end
            OP_DIVU: is_div_s = 1'b1;
            default: is_mul_s = 1'b0;
        endcase
    end

    // One multiplier serves both flavours: sign-extend only for MULT
    assign mul_a_s = {{32{mul_signed_r & quo_r[31]}}, quo_r};
    assign mul_b_s = {{32{mul_signed_r & opb_r[31]}}, opb_r};
    assign prod_s  = mul_a_s * mul_b_s;

    // Restoring step: a borrow out of the 33-bit subtract means "no subtract"
    assign shl_s      = {rem_r, quo_r[31]};
    assign diff_s     = shl_s - {1'b0, opb_r};
    assign rem_step_s = diff_s[32] ? shl_s[31:0] : diff_s[31:0];
    assign quo_step_s = {quo_r[30:0], ~diff_s[32]};
    assign quo_fix_s  = neg_if(quo_step_s, quo_neg_r);
    assign rem_fix_s  = neg_if(rem_step_s, rem_neg_r);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        state_nxt_s = state_r;
        if (bus.flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req && is_mul_s) begin
                        state_nxt_s = ST_MUL;
                    end else if (bus.req && is_div_s) begin
                        state_nxt_s = ST_DIV;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (cnt_r == MUL_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_MUL;
                    end
                end
                ST_DIV: begin
                    if (cnt_r == DIV_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DIV;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: stall and the write/accept strobes for the datapath
    always_comb begin
        stall_s    = 1'b0;
        busy_s     = 1'b0;
        acc_mul_s  = 1'b0;
        acc_div_s  = 1'b0;
        mthi_we_s  = 1'b0;
        mtlo_we_s  = 1'b0;
        mul_done_s = 1'b0;
        div_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req && !bus.flush) begin
                    stall_s   = is_mul_s | is_div_s;
                    acc_mul_s = is_mul_s;
                    acc_div_s = is_div_s;
                    mthi_we_s = (bus.mdu_op == OP_MTHI);
                    mtlo_we_s = (bus.mdu_op == OP_MTLO);
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_MUL: begin
                stall_s    = 1'b1;
                busy_s     = 1'b1;
                mul_done_s = (cnt_r == MUL_LAST) && !bus.flush;
            end
            ST_DIV: begin
                stall_s    = 1'b1;
                busy_s     = 1'b1;
                div_done_s = (cnt_r == DIV_LAST) && !bus.flush && !div_zero_r;
            end
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Operand latches, iteration counter and divider working registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= 5'd0;
            opb_r        <= 32'd0;
            rem_r        <= 32'd0;
            quo_r        <= 32'd0;
            mul_signed_r <= 1'b0;
            quo_neg_r    <= 1'b0;
            rem_neg_r    <= 1'b0;
            div_zero_r   <= 1'b0;
        end else if (acc_mul_s) begin
            cnt_r        <= 5'd0;
            quo_r        <= bus.src_a;
            opb_r        <= bus.src_b;
            mul_signed_r <= (bus.mdu_op == OP_MULT);
        end else if (acc_div_s) begin
            cnt_r      <= 5'd0;
            rem_r      <= 32'd0;
            quo_r      <= neg_if(bus.src_a, div_signed_s & bus.src_a[31]);
            opb_r      <= neg_if(bus.src_b, div_signed_s & bus.src_b[31]);
            quo_neg_r  <= div_signed_s & (bus.src_a[31] ^ bus.src_b[31]);
            rem_neg_r  <= div_signed_s & bus.src_a[31];
            div_zero_r <= (bus.src_b == 32'd0);
        end else if (state_r == ST_DIV) begin
            cnt_r <= cnt_r + 5'd1;
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
        end else if (state_r == ST_MUL) begin
            cnt_r <= cnt_r + 5'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (mul_done_s) begin
            hi_r <= prod_s[63:32];
            lo_r <= prod_s[31:0];
        end else if (div_done_s) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
        end else if (mthi_we_s) begin
            hi_r <= bus.src_a;
        end else if (mtlo_we_s) begin
            lo_r <= bus.src_a;
        end else begin
            hi_r <= hi_r;
        end
    end

    assign bus.stall = stall_s;
    assign bus.busy  = busy_s;
    assign bus.hi_o  = hi_r;
    assign bus.lo_o  = lo_r;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized self-checking bench for mdu_ctrl against an arithmetic HI/LO and
// stall-length model.
module tb_mdu_ctrl;
    localparam int MUL_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int exp_stall(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MUL_LAT + 1;
        if (op == 3'd3 || op == 3'd4) return 33;
        return 0;
    endfunction

    // Architectural effect of one completed instruction on HI/LO
    function automatic void model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin sp = sa * sb; {m_hi, m_lo} = sp; end
            3'd2: begin up = ua * ub; {m_hi, m_lo} = up; end
            3'd3: if (b != 32'd0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            3'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        int exp_n;
        bit done;
        exp_n = exp_stall(op);
        @(negedge clk);
        bus.req = 1'b1; bus.mdu_op = op; bus.src_a = a; bus.src_b = b; bus.flush = 1'b0;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (bus.stall) begin
                check("busy_run", {31'd0, bus.busy}, {31'd0, (c > 0)});
                n++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        check("stall_len", n, exp_n);
        model_apply(op, a, b);
        if (exp_n > 0) begin
            check("busy_done", {31'd0, bus.busy}, 32'd0);
            check("hi_done", bus.hi_o, m_hi);
            check("lo_done", bus.lo_o, m_lo);
        end
        @(negedge clk);
        bus.req = 1'b0; bus.mdu_op = 3'd0;
        #1;
        check("stall_idle", {31'd0, bus.stall}, 32'd0);
        check("hi_after", bus.hi_o, m_hi);
        check("lo_after", bus.lo_o, m_lo);
    endtask

    // Kill the instruction at cycle k (0 = acceptance cycle); HI/LO must not move
    task automatic run_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
        @(negedge clk);
        bus.req = 1'b1; bus.mdu_op = op; bus.src_a = a; bus.src_b = b;
        for (int c = 0; c <= k; c++) begin
            bus.flush = (c == k);
            #1;
            check("stall_pre_flush", {31'd0, bus.stall}, {31'd0, (exp_stall(op) > 0) && (c > 0 || c < k)});
            @(negedge clk);
        end
        bus.req = 1'b0; bus.mdu_op = 3'd0; bus.flush = 1'b0;
        #1;
        check("stall_flushed", {31'd0, bus.stall}, 32'd0);
        check("busy_flushed", {31'd0, bus.busy}, 32'd0);
        check("hi_flushed", bus.hi_o, m_hi);
        check("lo_flushed", bus.lo_o, m_lo);
        @(negedge clk);
        #1;
        check("hi_flushed_late", bus.hi_o, m_hi);
        check("lo_flushed_late", bus.lo_o, m_lo);
    endtask

    task automatic run_reset(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
        @(negedge clk);
        bus.req = 1'b1; bus.mdu_op = op; bus.src_a = a; bus.src_b = b; bus.flush = 1'b0;
        for (int c = 0; c <= k; c++) begin
            rst = (c == k);
            #1;
            check("stall_pre_rst", {31'd0, bus.stall}, 32'd1);
            @(negedge clk);
        end
        rst = 1'b0; bus.req = 1'b0; bus.mdu_op = 3'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1;
        check("stall_rst", {31'd0, bus.stall}, 32'd0);
        check("busy_rst", {31'd0, bus.busy}, 32'd0);
        check("hi_rst", bus.hi_o, m_hi);
        check("lo_rst", bus.lo_o, m_lo);
    endtask

    initial begin
        logic [2:0] op;
        rst = 1'b1;
        bus.req = 1'b0; bus.mdu_op = 3'd0; bus.src_a = 32'd0; bus.src_b = 32'd0; bus.flush = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_hi", bus.hi_o, 32'd0);
        check("rst_lo", bus.lo_o, 32'd0);

        run_op(3'd1, 32'hFFFF_FFFD, 32'd5);
        check("mult_neg_hi", m_hi, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd4, 32'd100, 32'd7);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd5, 32'h11, 32'd0);
        run_op(3'd6, 32'h22, 32'd0);
        run_op(3'd4, 32'd5, 32'd0);
        run_flush(3'd3, 32'd1000, 32'd3, 10);
        run_op(3'd1, 32'd6, 32'd7);
        run_flush(3'd1, 32'd9, 32'd9, MUL_LAT);
        run_flush(3'd4, 32'd77, 32'd5, 32);
        run_op(3'd5, 32'hCAFE_0001, 32'd0);
        run_reset(3'd1, 32'd3, 32'd4, 1);
        run_op(3'd6, 32'h1234_5678, 32'd0);
        run_flush(3'd5, 32'hDEAD_BEEF, 32'd0, 0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            run_op(op, pick_val(), pick_val());
        end
        for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(1, 4));
            run_flush(op, pick_val(), pick_val(), $urandom_range(0, exp_stall(op) - 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
